// File: rtl/uart_pkg.sv
// uart_pkg: parity mode encodings and transmitter FSM state encoding
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy output; depth must be a power of two
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] level_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i) rd_q <= rd_q + AW'(1);
         level_q <= level_q + LW'(push_i) - LW'(pop_i);
      end
   end
   always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= wdata_i;
   assign rdata_o = mem_q[rd_q];
   assign level_o = level_q;
   assign full_o  = level_q == LW'(DEPTH);
   assign empty_o = level_q == '0;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; tx is registered from the current state, giving a 2-cycle push-to-start latency
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = PAR_NONE,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        in_valid,
   input  logic [DATA_BITS-1:0]        in_data,
   output logic                        in_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CW = $clog2(BAUD_DIV);
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d, head;
   logic par_q, par_d, tx_q, tx_d;
   logic push, pop, full, empty, tick;
   sync_fifo #(
      .WIDTH(DATA_BITS),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .pop_i  (pop),
      .wdata_i(in_data),
      .rdata_o(head),
      .level_o(fifo_level),
      .full_o (full),
      .empty_o(empty)
   );
   assign in_ready = en && !rst && !full;
   assign push     = in_valid && in_ready;
   assign tick     = cnt_q == CW'(BAUD_DIV - 1);
   assign busy     = (state_q != ST_IDLE) || !empty;
   assign tx       = tx_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      pop     = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (!empty) begin
                  state_d = ST_START;
                  pop     = 1'b1;
               end
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: if (tick) begin
               sh_d  = sh_q >> 1;
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
               end
            end
            ST_PAR: if (tick) state_d = ST_STOP;
            ST_STOP: if (tick) begin
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = empty ? ST_IDLE : ST_START;
                  pop     = !empty;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // the popped word is latched together with its parity so the FIFO head is free to change
      if (pop) begin
         sh_d  = head;
         par_d = (^head) ^ (PARITY == PAR_ODD);
      end
      tx_d = !en                  ? 1'b1 :
             state_q == ST_START ? 1'b0 :
             state_q == ST_DATA  ? sh_q[0] :
             state_q == ST_PAR   ? par_q : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer divide), with BAUD_DIV >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning input FIFO entries; a power of 2, >= 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; one clock only, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port en, input, 1 bit: transmit enable, a hard gate.
REQ-010 SHALL have port in_valid, input, 1 bit: a word is offered.
REQ-011 SHALL have port in_data, input, DATA_BITS: the offered word.
REQ-012 SHALL have port in_ready, output, 1 bit: the FIFO can accept a word.
REQ-013 SHALL have port tx, output, 1 bit: serial line, registered, idle high.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 SHALL drive in_ready = en && (fifo_level != FIFO_DEPTH); a push occurs on an edge where in_valid && in_ready.
REQ-017 SHALL use an FSM with states IDLE, START, DATA, PAR, STOP:
- IDLE->START when en and the FIFO is non-empty; this pops the head word.
- START->DATA after 1 bit time.
- DATA->PAR (PARITY != 0) or STOP (PARITY == 0) after DATA_BITS bit times.
- PAR->STOP after 1 bit time.
- STOP->START (FIFO non-empty) or IDLE after STOP_BITS bit times.
REQ-018 SHALL hold every bit on tx for exactly BAUD_DIV clk cycles; the baud counter restarts at frame start, so the start bit is never short.
REQ-019 SHALL send start bit 0, then data LSB first, then the parity bit, then stop bits of 1.
REQ-020 SHALL set the parity bit to the XOR of the data bits for even parity, and to its inverse for odd parity.
REQ-021 SHALL begin the start bit on tx after the second rising edge following a push into an empty FIFO while IDLE (2-cycle latency).
REQ-022 SHALL send back-to-back frames with zero idle cycles between the last stop bit and the next start bit.
REQ-023 SHALL perform a push and a pop on the same edge when both occur; fifo_level is then unchanged.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; a push when full and a pop when empty never occur.
REQ-025 When en is low: on the next edge the FSM goes to IDLE and tx goes to 1. Any partial frame is abandoned and not resent. FIFO contents and fifo_level are retained. in_ready is 0.
REQ-026 On en rising: the next frame starts from a fresh start bit per REQ-017.

Reset
REQ-027 On rst high at a clk edge:
- tx=1, state=IDLE, fifo_level=0, in_ready=0 that cycle, busy=0.
- Baud and bit counters cleared; FIFO pointers cleared.
- No frame is emitted on reset.
REQ-028 rst SHALL take priority over en and over a simultaneous push; a rst mid-frame truncates the frame, and tx is 1 on the next cycle.

Structure
REQ-029 SHALL define the parity mode encodings (NONE/EVEN/ODD) and the FSM state encoding in the shared package uart_pkg.
REQ-030 SHALL implement the FIFO as one sub-module, sync_fifo (parametrised width and depth, with level output); the baud counter and FSM stay in the top level.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, BAUD_DIV=10 unless stated)
REQ-031 8N1, push 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles; frame 100 cycles; start bit begins 2 cycles after the push.
REQ-032 8E1 push 0x07 -> parity bit 1; 8O1 push 0x07 -> parity bit 0; 7E2 push 0x00 -> parity 0, two stop bits, frame 110 cycles.
REQ-033 FIFO_DEPTH=4, in_valid held high for 6 cycles -> 5 words accepted, in_ready low on the 6th cycle; 5 frames sent gap-free totalling 500 cycles; busy falls after the last stop bit.
REQ-034 rst asserted at cycle 35 of a frame with 3 words queued -> tx=1 the next cycle, fifo_level=0, no further frames.
REQ-035 en dropped mid-data bit with 2 words queued -> tx=1 the next cycle, fifo_level=2; en restored -> 2 complete frames follow, the abandoned word is not resent.
